pix_serializer: RTL
===================

Name: pix_serializer

Overview:
- Parametrised pixel serializer for the CGA/Tandy video path. It generalises the fixed 2-bit graphics mux into a buffered shifter with selectable 1/2/4 bits per pixel and a programmable horizontal pixel repeat.
- It accepts VRAM fetch words through a valid/ready handshake into a small FIFO. It emits one pixel index per clock, with display-enable, cursor and attribute side channels delayed to line up.
- It sits between the VRAM fetch sequencer and the attribute/colour stage.

Parameters:
- FETCH_BYTES, 2, bytes per fetch word (1..4); word width W = 8*FETCH_BYTES.
- FIFO_DEPTH, 2, fetch FIFO entries (power of two, >=2).
- PIPE_DLY, 2, clock delay applied to display_enable/cursor/attr side channels (>=1).

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- mode  in  2  00 text 1bpp, 01 graphics 1bpp, 10 graphics 2bpp, 11 graphics 4bpp
- pix_rep  in  2  each pixel held 2^pix_rep clocks (3 treated as 2)
- start  in  1  line start; synchronous flush
- fetch_data  in  W  VRAM word, leftmost pixel in MSBs
- fetch_valid  in  1  fetch_data valid
- fetch_ready  out  1  FIFO can accept a word
- display_enable  in  1  active-display qualifier; the shifter advances only when high
- cursor_in  in  1  cursor flag
- attr_in  in  8  attribute byte
- pix_idx  out  4  pixel colour index
- de_out  out  1  delayed display_enable
- cursor_out  out  1  delayed cursor_in
- attr_out  out  8  delayed attr_in
- underflow  out  1  sticky starvation flag

Behaviour:
- Reset (async, reset_n low): FIFO empty, shifter empty, repeat counter 0, all outputs 0, including fetch_ready. fetch_ready goes to 1 on the first clock after reset_n deasserts.
- bpp: 1 for modes 00/01, 2 for mode 10, 4 for mode 11. Pixels per word P = W/bpp. The shifter shifts left by bpp.
- Text mode: the input word is already-expanded character bits. pix_idx = {3'b0, bit}.
- Graphics 1/2bpp: pix_idx is the pixel value zero-extended.
- FIFO push when fetch_valid && fetch_ready. fetch_ready = !full, registered from the occupancy count.
- Push and pop in the same cycle leave the count unchanged. A word offered while fetch_ready=0 is not accepted.
- Pop/load: the shifter loads the FIFO head when display_enable is high and either the shifter is empty or it is finishing its last pixel's last repeat clock. This gives seamless back-to-back words.
- The load occurs only if the FIFO is non-empty.
- Repeat counter: counts 0..2^pix_rep-1. The shifter steps to the next pixel when the counter wraps.
- pix_idx is registered: the first pixel of a word appears 1 clock after the load clock.
- display_enable low: shifter and counter hold, and pix_idx = 0.
- Underflow: display_enable high, shifter empty and FIFO empty sets underflow=1 and forces pix_idx=0. underflow stays set until start or reset.
- start (synchronous, priority over push/pop): empties FIFO and shifter, clears the counter and underflow, and drives pix_idx=0 next clock. A word presented in the start cycle is dropped.
- Changing mode or pix_rep mid-word: takes effect at the next pixel step. Verification need not check pixel values across such a change.
- Side channels: de_out/cursor_out/attr_out equal their inputs PIPE_DLY clocks earlier. They are unaffected by start and cleared only by reset.

Optional Feature:
- Macro PIXSER_PALETTE_EN.
- Defined: adds ports pal_we (in 1), pal_addr (in 4), pal_data (in 4) and a 16x4 palette register file.
  - Writes take effect the next clock.
  - pix_idx = palette[raw index], which adds one clock of pixel latency.
  - Side channels get PIPE_DLY+1 delay.
  - Palette resets to identity (entry n = n).
- Undefined: no extra ports, raw index out, latencies as above.

Test Plan:
1. mode=10, pix_rep=0, DE=1, push 16'hE41B -> pix_idx 3,2,1,0,0,1,2,3 on consecutive clocks starting 1 clock after load; underflow stays 0 if a second word follows.
2. mode=11, pix_rep=1, push 16'h5AF0 -> pix_idx 5,5,A,A,F,F,0,0.
3. mode=00, pix_rep=0, push 16'h8001 -> 1, fourteen 0s, 1; the next word 16'hFFFF follows with no gap cycle (sixteen 1s).
4. DE=0, push two words -> fetch_ready=0 after the second accept; a third fetch_valid is not accepted; raising DE drains and fetch_ready returns to 1.
5. DE=1 with an empty FIFO -> underflow=1, pix_idx=0; pulse start -> underflow=0 next clock; new data serializes normally.
6. Assert reset_n low mid-word -> outputs 0 immediately (async). After release, the FIFO is empty and the first pushed word serializes from its MSB pixel.

Source files
------------

// File: rtl/pix_serializer.sv
// Buffered CGA/Tandy pixel serializer: fetch FIFO, 1/2/4 bpp shifter with pixel repeat, delayed side channels.
// Optional PIXSER_PALETTE_EN adds a 16x4 palette lookup stage (one extra clock on pixels and side channels).
module pix_serializer #(
  parameter int unsigned FETCH_BYTES = 2,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned PIPE_DLY    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               mode,
  input  logic [1:0]               pix_rep,
  input  logic                     start,
  input  logic [8*FETCH_BYTES-1:0] fetch_data,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic                     display_enable,
  input  logic                     cursor_in,
  input  logic [7:0]               attr_in,
`ifdef PIXSER_PALETTE_EN
  input  logic                     pal_we,
  input  logic [3:0]               pal_addr,
  input  logic [3:0]               pal_data,
`endif
  output logic [3:0]               pix_idx,
  output logic                     de_out,
  output logic                     cursor_out,
  output logic [7:0]               attr_out,
  output logic                     underflow
);

  localparam int unsigned W  = 8 * FETCH_BYTES;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(W + 1);
  localparam int unsigned SW = 10;
`ifdef PIXSER_PALETTE_EN
  localparam int unsigned SIDE_DLY = PIPE_DLY + 1;
`else
  localparam int unsigned SIDE_DLY = PIPE_DLY;
`endif

  // Fetch FIFO
  logic [W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Shifter state
  logic [W-1:0]  shreg;
  logic [W-1:0]  shreg_d;
  logic [BW-1:0] bits_left;
  logic [BW-1:0] bits_d;
  logic [1:0]    rep_cnt;
  logic [1:0]    rep_d;
  logic [2:0]    bpp;
  logic [BW-1:0] bpp_w;
  logic [1:0]    rep_max;
  logic          sh_empty;
  logic          last_rep;
  logic          last_pix;
  logic          load;
  logic          raw_vld_d;
  logic [3:0]    raw_d;
  logic          underflow_d;

  function automatic logic [3:0] top_pix(input logic [W-1:0] w, input logic [1:0] m);
    logic [3:0] p;
    case (m)
      2'b10:   p = {2'b00, w[W-1 -: 2]};
      2'b11:   p = w[W-1 -: 4];
      default: p = {3'b000, w[W-1]};
    endcase
    return p;
  endfunction

  assign fifo_empty = (count == CW'(0));
  assign push       = fetch_valid && fetch_ready && !start;
  assign pop        = load && !start;

  // Bits per pixel and repeat terminal count
  always_comb begin
    bpp     = 3'd1;
    rep_max = 2'd0;
    case (mode)
      2'b10:   bpp = 3'd2;
      2'b11:   bpp = 3'd4;
      default: bpp = 3'd1;
    endcase
    case (pix_rep)
      2'd0:    rep_max = 2'd0;
      2'd1:    rep_max = 2'd1;
      default: rep_max = 2'd3;
    endcase
  end

  assign bpp_w    = BW'(bpp);
  assign sh_empty = (bits_left == BW'(0));
  assign last_rep = (rep_cnt == rep_max);
  assign last_pix = !sh_empty && (bits_left <= bpp_w);
  // Load on empty shifter or on the final clock of the final pixel for seamless words
  assign load     = display_enable && !fifo_empty && (sh_empty || (last_pix && last_rep));

  always_comb begin
    count_d = count;
    if (start) begin
      count_d = CW'(0);
    end else begin
      case ({push, pop})
        2'b10:   count_d = count + CW'(1);
        2'b01:   count_d = count - CW'(1);
        default: count_d = count;
      endcase
    end
  end

  // Shifter next state; start has priority, then load, then step/repeat
  always_comb begin
    shreg_d = shreg;
    bits_d  = bits_left;
    rep_d   = rep_cnt;
    if (start) begin
      shreg_d = '0;
      bits_d  = BW'(0);
      rep_d   = 2'd0;
    end else if (load) begin
      shreg_d = fifo_mem[rd_ptr];
      bits_d  = BW'(W);
      rep_d   = 2'd0;
    end else if (display_enable && !sh_empty) begin
      if (last_rep) begin
        rep_d   = 2'd0;
        shreg_d = shreg << bpp;
        bits_d  = last_pix ? BW'(0) : (bits_left - bpp_w);
      end else begin
        rep_d = rep_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    raw_vld_d   = !start && display_enable && (bits_d != BW'(0));
    raw_d       = raw_vld_d ? top_pix(shreg_d, mode) : 4'h0;
    underflow_d = start ? 1'b0
                        : (underflow || (display_enable && sh_empty && fifo_empty));
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= fetch_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fetch_ready <= 1'b0;
      shreg       <= '0;
      bits_left   <= '0;
      rep_cnt     <= '0;
      underflow   <= 1'b0;
    end else begin
      if (start) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count       <= count_d;
      fetch_ready <= (count_d != CW'(FIFO_DEPTH));
      shreg       <= shreg_d;
      bits_left   <= bits_d;
      rep_cnt     <= rep_d;
      underflow   <= underflow_d;
    end
  end

`ifdef PIXSER_PALETTE_EN
  logic [3:0] pal [16];
  logic [3:0] raw_q;
  logic       raw_vld_q;

  // Raw index stage followed by palette lookup
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 16; n++) pal[n] <= 4'(n);
      raw_q     <= 4'h0;
      raw_vld_q <= 1'b0;
      pix_idx   <= 4'h0;
    end else begin
      if (pal_we) pal[pal_addr] <= pal_data;
      raw_q     <= raw_d;
      raw_vld_q <= raw_vld_d;
      pix_idx   <= (start || !raw_vld_q) ? 4'h0 : pal[raw_q];
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pix_idx <= 4'h0;
    else          pix_idx <= raw_d;
  end
`endif

  // Side-channel delay line, deliberately untouched by start
  logic [SW-1:0] side_q [SIDE_DLY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SIDE_DLY); i++) side_q[i] <= '0;
    end else begin
      side_q[0] <= {display_enable, cursor_in, attr_in};
      for (int i = 1; i < int'(SIDE_DLY); i++) side_q[i] <= side_q[i-1];
    end
  end

  assign {de_out, cursor_out, attr_out} = side_q[SIDE_DLY-1];

endmodule
